// File: rtl/nts_rx_arb_pkg.sv
// Shared types and constants for the RX packet buffer read arbiter.
package nts_rx_arb_pkg;

   localparam int unsigned WS_W   = 3;
   localparam int unsigned DATA_W = 64;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CHECK   = 2'd2,
      ST_WAIT_DV = 2'd3
   } state_t;

   // Buffer word sizes; anything above WS_MAX is rejected locally.
   typedef enum logic [WS_W-1:0] {
      WS_8  = 3'd0,
      WS_16 = 3'd1,
      WS_32 = 3'd2,
      WS_64 = 3'd3
   } wordsize_t;

   localparam logic [WS_W-1:0] WS_MAX = WS_64;

   // True when the buffer can serve this word size.
   function automatic logic ws_valid(input logic [WS_W-1:0] ws);
      ws_valid = (ws <= WS_MAX);
   endfunction

endpackage

// File: rtl/nts_rr_pick.sv
// Combinational round-robin pick: first pending index at or after rr_ptr.
module nts_rr_pick #(
   parameter  int unsigned NUM_REQ = 3,
   localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [PTR_W-1:0]   grant,
   output logic               any_pending
);

   int unsigned     idx;
   logic [PTR_W-1:0] cand;

   // Scan from farthest to nearest so the nearest pending slot wins.
   always_comb begin
      grant       = '0;
      idx         = 0;
      cand        = '0;
      any_pending = |pending;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = 32'(rr_ptr) + 32'(i);
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         cand = PTR_W'(idx);
         if (pending[cand]) begin
            grant = cand;
         end
      end
   end

endmodule

// File: rtl/nts_rx_buffer_arbiter.sv
// Round-robin arbiter sharing the RX buffer read port among NUM_REQ requesters.
module nts_rx_buffer_arbiter
   import nts_rx_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned NUM_REQ        = 3,
   parameter int unsigned MAX_RETRY      = 7,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                              i_clk,
   input  logic                              i_areset,
   input  logic                              i_clear,
   input  logic [NUM_REQ-1:0]                i_req_rd_en,
   input  logic [NUM_REQ*(ADDR_WIDTH+3)-1:0] i_req_addr,
   input  logic [NUM_REQ*WS_W-1:0]           i_req_wordsize,
   output logic [NUM_REQ-1:0]                o_req_wait,
   output logic [NUM_REQ-1:0]                o_req_rd_dv,
   output logic [NUM_REQ-1:0]                o_req_error,
   output logic [DATA_W-1:0]                 o_req_rd_data,
   output logic                              o_access_port_rd_en,
   output logic [ADDR_WIDTH+2:0]             o_access_port_addr,
   output logic [WS_W-1:0]                   o_access_port_wordsize,
   input  logic                              i_access_port_wait,
   input  logic                              i_access_port_rd_dv,
   input  logic [DATA_W-1:0]                 i_access_port_rd_data
);

   localparam int unsigned BA_W    = ADDR_WIDTH + 3;
   localparam int unsigned PTR_W   = $clog2(NUM_REQ);
   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     grant_q, grant_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [NUM_REQ-1:0]   pending_q, pending_d;
   logic                 rd_en_q, rd_en_d;
   logic [BA_W-1:0]      addr_q, addr_d;
   logic [WS_W-1:0]      ws_q, ws_d;
   logic [NUM_REQ-1:0]   dv_q, dv_d;
   logic [NUM_REQ-1:0]   err_q, err_d;
   logic [DATA_W-1:0]    data_q, data_d;

   logic [NUM_REQ-1:0]   accept;
   logic [NUM_REQ-1:0]   reject;
   logic [BA_W-1:0]      slot_addr [NUM_REQ];
   logic [WS_W-1:0]      slot_ws   [NUM_REQ];
   logic [PTR_W-1:0]     pick;
   logic                 any_pending;
   logic                 fail;
   logic                 done;

   // Per-requester capture: a strobe is only seen while that requester is idle.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
      logic [WS_W-1:0] req_ws;
      logic            strobe;
      logic [BA_W-1:0] addr_r;
      logic [WS_W-1:0] ws_r;

      assign req_ws    = i_req_wordsize[g*WS_W +: WS_W];
      assign strobe    = i_req_rd_en[g] && !pending_q[g];
      assign accept[g] = strobe && ws_valid(req_ws);
      assign reject[g] = strobe && !ws_valid(req_ws);
      assign slot_addr[g] = addr_r;
      assign slot_ws[g]   = ws_r;

      // Hold the captured address and word size until granted.
      always_ff @(posedge i_clk) begin
         if (i_areset) begin
            addr_r <= '0;
            ws_r   <= '0;
         end else if (accept[g]) begin
            addr_r <= i_req_addr[g*BA_W +: BA_W];
            ws_r   <= req_ws;
         end
      end
   end

   nts_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .pending     (pending_q),
      .rr_ptr      (rr_ptr_q),
      .grant       (pick),
      .any_pending (any_pending)
   );

   // State and registered outputs; clear aborts exactly like reset.
   always_ff @(posedge i_clk) begin
      if (i_areset || i_clear) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         retry_q   <= '0;
         tmo_q     <= '0;
         pending_q <= '0;
         rd_en_q   <= 1'b0;
         addr_q    <= '0;
         ws_q      <= '0;
         dv_q      <= '0;
         err_q     <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         retry_q   <= retry_d;
         tmo_q     <= tmo_d;
         pending_q <= pending_d;
         rd_en_q   <= rd_en_d;
         addr_q    <= addr_d;
         ws_q      <= ws_d;
         dv_q      <= dv_d;
         err_q     <= err_d;
         data_q    <= data_d;
      end
   end

   // Buffer handshake sequencing and completion bookkeeping.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      pending_d = pending_q | accept;
      rd_en_d   = 1'b0;
      addr_d    = addr_q;
      ws_d      = ws_q;
      dv_d      = '0;
      err_d     = reject;
      data_d    = data_q;
      fail      = 1'b0;
      done      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_pending) begin
               grant_d = pick;
               addr_d  = slot_addr[pick];
               ws_d    = slot_ws[pick];
               rd_en_d = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (i_access_port_wait) begin
               tmo_d   = '0;
               state_d = ST_WAIT_DV;
            end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
               retry_d = retry_q + RETRY_W'(1);
               rd_en_d = 1'b1;
               state_d = ST_ISSUE;
            end else begin
               fail = 1'b1;
            end
         end
         ST_WAIT_DV: begin
            if (i_access_port_rd_dv) begin
               data_d        = i_access_port_rd_data;
               dv_d[grant_q] = 1'b1;
               done          = 1'b1;
            end else if (!i_access_port_wait) begin
               fail = 1'b1;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               fail = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (fail) begin
         err_d[grant_q] = 1'b1;
         done           = 1'b1;
      end
      if (done) begin
         pending_d[grant_q] = 1'b0;
         retry_d            = '0;
         rr_ptr_d           = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
         state_d            = ST_IDLE;
      end
   end

   assign o_req_wait             = pending_q;
   assign o_req_rd_dv            = dv_q;
   assign o_req_error            = err_q;
   assign o_req_rd_data          = data_q;
   assign o_access_port_rd_en    = rd_en_q;
   assign o_access_port_addr     = addr_q;
   assign o_access_port_wordsize = ws_q;

endmodule

// File: tb/tb_nts_rx_buffer_arbiter.sv
// Scoreboard bench for nts_rx_buffer_arbiter with a scripted buffer model.
module tb_nts_rx_buffer_arbiter;

   localparam int unsigned AW = 10;
   localparam int unsigned N  = 3;
   localparam int unsigned BA = AW + 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            areset;
   logic            clr;
   logic [N-1:0]    req_rd_en;
   logic [N*BA-1:0] req_addr;
   logic [N*3-1:0]  req_ws;
   logic [N-1:0]    req_wait;
   logic [N-1:0]    req_rd_dv;
   logic [N-1:0]    req_error;
   logic [63:0]     req_rd_data;
   logic            ap_rd_en;
   logic [BA-1:0]   ap_addr;
   logic [2:0]      ap_ws;
   logic            bf_wait;
   logic            bf_dv;
   logic [63:0]     bf_data;

   nts_rx_buffer_arbiter dut (
      .i_clk                  (clk),
      .i_areset               (areset),
      .i_clear                (clr),
      .i_req_rd_en            (req_rd_en),
      .i_req_addr             (req_addr),
      .i_req_wordsize         (req_ws),
      .o_req_wait             (req_wait),
      .o_req_rd_dv            (req_rd_dv),
      .o_req_error            (req_error),
      .o_req_rd_data          (req_rd_data),
      .o_access_port_rd_en    (ap_rd_en),
      .o_access_port_addr     (ap_addr),
      .o_access_port_wordsize (ap_ws),
      .i_access_port_wait     (bf_wait),
      .i_access_port_rd_dv    (bf_dv),
      .i_access_port_rd_data  (bf_data)
   );

   typedef struct packed {
      logic [2:0]  idx;
      logic        err;
      logic [63:0] data;
   } rsp_t;

   logic [BA+2:0] exp_rd[$];
   rsp_t          exp_rsp[$];

   int errors    = 0;
   int checks    = 0;
   int cyc       = 0;
   int rd_pulses = 0;
   int t_req     = 0;
   int t_issue   = 0;
   int t_bdv     = 0;
   int t_rdv     = 0;

   // Buffer model knobs.
   int          bf_refuse = 0;
   int          bf_delay  = 3;
   bit          bf_drop   = 1'b0;
   bit          bf_fixed  = 1'b0;
   logic [63:0] bf_fixed_data = 64'd0;
   bit          bf_active = 1'b0;
   int          bf_cnt    = 0;
   logic [63:0] bf_next   = 64'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] data_for(input logic [BA-1:0] a);
      return 64'hDA7A_0000_0000_0000 | 64'(a);
   endfunction

   task automatic set_slot(input int k, input logic [BA-1:0] a, input logic [2:0] ws);
      req_addr[k*BA +: BA] = a;
      req_ws[k*3 +: 3]     = ws;
   endtask

   task automatic exp_read(input int k, input int times);
      for (int i = 0; i < times; i++) exp_rd.push_back({req_addr[k*BA +: BA], req_ws[k*3 +: 3]});
   endtask

   task automatic exp_resp(input int k, input logic err, input logic [63:0] d);
      rsp_t r;
      r.idx  = 3'(k);
      r.err  = err;
      r.data = d;
      exp_rsp.push_back(r);
   endtask

   task automatic strobe(input logic [N-1:0] mask);
      @(negedge clk);
      req_rd_en = mask;
      t_req     = cyc;
      @(negedge clk);
      req_rd_en = '0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while ((exp_rsp.size() != 0 || req_wait != '0 || bf_active || bf_wait || bf_dv) && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check({tag, "_timeout"}, 64'(n >= 200), 64'd0);
      check({tag, "_rd_left"}, 64'(exp_rd.size()), 64'd0);
      check({tag, "_rsp_left"}, 64'(exp_rsp.size()), 64'd0);
   endtask

   // Buffer model: accept (or refuse) each read, then dv or drop wait after bf_delay cycles.
   initial begin
      bf_wait = 1'b0;
      bf_dv   = 1'b0;
      bf_data = 64'd0;
      forever begin
         @(negedge clk);
         if (bf_dv) begin
            bf_dv   = 1'b0;
            bf_wait = 1'b0;
         end
         if (bf_active) begin
            if (bf_cnt <= 1) begin
               bf_active = 1'b0;
               if (bf_drop) begin
                  bf_wait = 1'b0;
               end else begin
                  bf_dv   = 1'b1;
                  bf_data = bf_next;
                  t_bdv   = cyc;
               end
            end else begin
               bf_cnt--;
            end
         end else if (ap_rd_en) begin
            if (bf_refuse > 0) begin
               bf_refuse--;
            end else begin
               bf_wait   = 1'b1;
               bf_active = 1'b1;
               bf_cnt    = bf_delay;
               bf_next   = bf_fixed ? bf_fixed_data : data_for(ap_addr);
            end
         end
      end
   end

   // Monitor: compare buffer reads and requester responses against the scoreboard.
   initial begin
      logic [BA+2:0] e;
      rsp_t          r;
      logic [N-1:0]  wd;
      logic [N-1:0]  we;
      forever begin
         @(negedge clk);
         if (ap_rd_en) begin
            rd_pulses++;
            t_issue = cyc;
            if (exp_rd.size() == 0) begin
               check("rd_unexpected", 64'd1, 64'd0);
            end else begin
               e = exp_rd.pop_front();
               check("rd_addr_ws", 64'({ap_addr, ap_ws}), 64'(e));
            end
         end
         if ((req_rd_dv | req_error) != '0) begin
            if (req_rd_dv != '0) t_rdv = cyc;
            if (exp_rsp.size() == 0) begin
               check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               r  = exp_rsp.pop_front();
               wd = r.err ? '0 : (N'(1) << r.idx);
               we = r.err ? (N'(1) << r.idx) : '0;
               check("rsp_dv_err", 64'({req_rd_dv, req_error}), 64'({wd, we}));
               if (!r.err) check("rsp_data", req_rd_data, r.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int p0;
      areset    = 1'b1;
      clr       = 1'b0;
      req_rd_en = '0;
      req_addr  = '0;
      req_ws    = '0;
      repeat (3) @(negedge clk);
      check("rst_wait", 64'(req_wait), 64'd0);
      check("rst_dv", 64'(req_rd_dv), 64'd0);
      check("rst_err", 64'(req_error), 64'd0);
      check("rst_data", req_rd_data, 64'd0);
      check("rst_ap", 64'({ap_rd_en, ap_addr, ap_ws}), 64'd0);
      areset = 1'b0;
      @(negedge clk);

      // Single read with fixed data and latency checks.
      bf_fixed      = 1'b1;
      bf_fixed_data = 64'h0123456789ABCDEF;
      bf_delay      = 3;
      set_slot(0, 13'h010, 3'd3);
      exp_read(0, 1);
      exp_resp(0, 1'b0, 64'h0123456789ABCDEF);
      strobe(3'b001);
      wait_done("single");
      check("lat_issue", 64'(t_issue - t_req), 64'd2);
      check("lat_dv", 64'(t_rdv - t_bdv), 64'd1);
      check("single_wait", 64'(req_wait), 64'd0);
      bf_fixed = 1'b0;

      // Contention: order 0,1,2, then one req0 read, then 1,2,0.
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      bf_delay = 2;
      set_slot(0, 13'h100, 3'd2);
      set_slot(1, 13'h208, 3'd1);
      set_slot(2, 13'h30C, 3'd0);
      for (int k = 0; k < 3; k++) begin
         exp_read(k, 1);
         exp_resp(k, 1'b0, data_for(req_addr[k*BA +: BA]));
      end
      strobe(3'b111);
      wait_done("rr1");
      exp_read(0, 1);
      exp_resp(0, 1'b0, data_for(13'h100));
      strobe(3'b001);
      wait_done("rr_single");
      for (int j = 1; j < 4; j++) begin
         exp_read(j % 3, 1);
         exp_resp(j % 3, 1'b0, data_for(req_addr[(j % 3)*BA +: BA]));
      end
      strobe(3'b111);
      wait_done("rr2");

      // Busy buffer: three refusals then success.
      bf_refuse = 3;
      set_slot(2, 13'h044, 3'd2);
      exp_read(2, 4);
      exp_resp(2, 1'b0, data_for(13'h044));
      p0 = rd_pulses;
      strobe(3'b100);
      wait_done("busy");
      check("busy_pulses", 64'(rd_pulses - p0), 64'd4);

      // Buffer never accepts: 1+MAX_RETRY issues then error.
      bf_refuse = 1000;
      set_slot(1, 13'h0A0, 3'd3);
      exp_read(1, 8);
      exp_resp(1, 1'b1, 64'd0);
      p0 = rd_pulses;
      strobe(3'b010);
      wait_done("never");
      check("never_pulses", 64'(rd_pulses - p0), 64'd8);
      bf_refuse = 0;

      // Local reject of an illegal word size.
      set_slot(0, 13'h123, 3'd5);
      exp_resp(0, 1'b1, 64'd0);
      p0 = rd_pulses;
      strobe(3'b001);
      check("rej_err", 64'(req_error), 64'd1);
      check("rej_wait", 64'(req_wait), 64'd0);
      wait_done("reject");
      check("rej_pulses", 64'(rd_pulses - p0), 64'd0);

      // Wait drops without data valid.
      bf_drop  = 1'b1;
      bf_delay = 3;
      set_slot(1, 13'h0F8, 3'd3);
      exp_read(1, 1);
      exp_resp(1, 1'b1, 64'd0);
      strobe(3'b010);
      wait_done("drop");

      // Wait stuck high past the timeout.
      bf_delay = 25;
      set_slot(2, 13'h1F0, 3'd1);
      exp_read(2, 1);
      exp_resp(2, 1'b1, 64'd0);
      strobe(3'b100);
      wait_done("stuck");
      bf_drop = 1'b0;

      // Clear during WAIT_DV with req1 queued; the late dv must be ignored.
      bf_delay = 8;
      set_slot(0, 13'h080, 3'd3);
      set_slot(1, 13'h0C0, 3'd3);
      exp_read(0, 1);
      exp_resp(0, 1'b0, data_for(13'h080));
      strobe(3'b001);
      repeat (4) @(negedge clk);
      strobe(3'b010);
      check("clr_pre_wait", 64'(req_wait), 64'd3);
      @(negedge clk);
      clr = 1'b1;
      exp_rd.delete();
      exp_rsp.delete();
      @(negedge clk);
      clr = 1'b0;
      check("clr_wait", 64'(req_wait), 64'd0);
      check("clr_ap_rd_en", 64'(ap_rd_en), 64'd0);
      wait_done("clr_abort");
      bf_delay = 2;
      exp_read(1, 1);
      exp_resp(1, 1'b0, data_for(13'h0C0));
      strobe(3'b010);
      wait_done("clr_new");

      // Repeated strobes while waiting are ignored.
      bf_delay = 4;
      set_slot(0, 13'h200, 3'd2);
      exp_read(0, 1);
      exp_resp(0, 1'b0, data_for(13'h200));
      p0 = rd_pulses;
      strobe(3'b001);
      set_slot(0, 13'h3F8, 3'd3);
      strobe(3'b001);
      strobe(3'b001);
      wait_done("ignore");
      check("ignore_pulses", 64'(rd_pulses - p0), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
